// File: rtl/sobel_matrix3.sv
// Sobel gradient magnitude on a 3x3 neighbourhood (centre pixel unused),
// two-stage valid/ready pipeline with a saturating edge counter.
module sobel_matrix3 #(
  parameter int P_PIXEL_DEPTH     = 8,
  parameter int P_COUNT_BIT_COUNT = 20
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET_N,
  input  logic [8*P_PIXEL_DEPTH-1:0]     I_PIXEL_MATRIX,
  input  logic                           I_VALID,
  output logic                           O_READY,
  input  logic [P_PIXEL_DEPTH-1:0]       I_THRESHOLD,
  input  logic                           I_CLEAR,
  output logic [P_PIXEL_DEPTH-1:0]       O_MAGNITUDE,
  output logic                           O_EDGE,
  output logic                           O_VALID,
  input  logic                           I_READY,
  output logic [P_COUNT_BIT_COUNT-1:0]   O_EDGE_COUNT
);

  localparam int P_PIXEL_MATRIX_BIT_COUNT = 8 * P_PIXEL_DEPTH;
  localparam int P_SUM_BIT_COUNT          = P_PIXEL_DEPTH + 3;
  localparam int GW                       = P_SUM_BIT_COUNT + 1;

  logic signed [GW-1:0]       px [8];
  logic signed [GW-1:0]       gx;
  logic signed [GW-1:0]       gy;

  logic                       s1_valid;
  logic signed [GW-1:0]       s1_gx;
  logic signed [GW-1:0]       s1_gy;
  logic [P_PIXEL_DEPTH-1:0]   s1_thr;

  logic                       s2_valid;
  logic [P_PIXEL_DEPTH-1:0]   s2_mag;
  logic                       s2_edge;

  logic [GW-1:0]              abs_gx;
  logic [GW-1:0]              abs_gy;
  logic [GW-1:0]              sum;
  logic [P_PIXEL_DEPTH-1:0]   mag_next;
  logic                       edge_next;

  logic                       en1;
  logic                       en2;
  logic                       delivered;

  assign en2       = !s2_valid || I_READY;
  assign en1       = !s1_valid || en2;
  assign O_READY   = en1;
  assign delivered = s2_valid && I_READY;

  // Order in the matrix: tl, t, tr, ml, mr, bl, b, br (tl in the MSBs).
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      px[i] = $signed({{(GW - P_PIXEL_DEPTH){1'b0}},
                       I_PIXEL_MATRIX[P_PIXEL_MATRIX_BIT_COUNT - 1 - i * P_PIXEL_DEPTH -: P_PIXEL_DEPTH]});
    end
    gx = (px[2] + (px[4] <<< 1) + px[7]) - (px[0] + (px[3] <<< 1) + px[5]);
    gy = (px[5] + (px[6] <<< 1) + px[7]) - (px[0] + (px[1] <<< 1) + px[2]);
  end

  always_comb begin
    abs_gx    = s1_gx[GW-1] ? -s1_gx : s1_gx;
    abs_gy    = s1_gy[GW-1] ? -s1_gy : s1_gy;
    sum       = abs_gx + abs_gy;
    mag_next  = (|sum[GW-1:P_PIXEL_DEPTH]) ? '1 : sum[P_PIXEL_DEPTH-1:0];
    edge_next = (mag_next >= s1_thr);
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      s1_valid <= 1'b0;
      s1_gx    <= '0;
      s1_gy    <= '0;
      s1_thr   <= '0;
    end else if (I_CLEAR) begin
      s1_valid <= 1'b0;
    end else if (en1) begin
      s1_valid <= I_VALID;
      if (I_VALID) begin
        s1_gx  <= gx;
        s1_gy  <= gy;
        s1_thr <= I_THRESHOLD;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      s2_valid <= 1'b0;
      s2_mag   <= '0;
      s2_edge  <= 1'b0;
    end else if (I_CLEAR) begin
      s2_valid <= 1'b0;
    end else if (en2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mag  <= mag_next;
        s2_edge <= edge_next;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_EDGE_COUNT <= '0;
    end else if (I_CLEAR) begin
      O_EDGE_COUNT <= '0;
    end else if (delivered && s2_edge && !(&O_EDGE_COUNT)) begin
      O_EDGE_COUNT <= O_EDGE_COUNT + 1'b1;
    end
  end

  assign O_VALID     = s2_valid;
  assign O_MAGNITUDE = s2_mag;
  assign O_EDGE      = s2_edge;

endmodule

// File: tb/tb_sobel_matrix3.sv
// Randomised scoreboard bench for sobel_matrix3; a second instance with a
// 2-bit edge counter shares the stimulus to exercise counter saturation.
module tb_sobel_matrix3;

  localparam int PD = 8;

  typedef struct {
    logic [PD-1:0] mag;
    logic          edge_flag;
  } exp_t;

  logic          I_CLK = 1'b0;
  logic          I_RESET_N = 1'b0;
  logic [8*PD-1:0] I_PIXEL_MATRIX = '0;
  logic          I_VALID = 1'b0;
  logic          O_READY;
  logic [PD-1:0] I_THRESHOLD = '0;
  logic          I_CLEAR = 1'b0;
  logic [PD-1:0] O_MAGNITUDE;
  logic          O_EDGE;
  logic          O_VALID;
  logic          I_READY = 1'b1;
  logic [19:0]   O_EDGE_COUNT;

  logic          small_ready;
  logic [PD-1:0] small_mag;
  logic          small_edge;
  logic          small_valid;
  logic [1:0]    small_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   model_count = 0;
  int   model_small = 0;
  bit   rand_ready  = 1'b0;

  sobel_matrix3 #(.P_PIXEL_DEPTH(PD), .P_COUNT_BIT_COUNT(20)) u_dut (
    .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_PIXEL_MATRIX(I_PIXEL_MATRIX),
    .I_VALID(I_VALID), .O_READY(O_READY), .I_THRESHOLD(I_THRESHOLD),
    .I_CLEAR(I_CLEAR), .O_MAGNITUDE(O_MAGNITUDE), .O_EDGE(O_EDGE),
    .O_VALID(O_VALID), .I_READY(I_READY), .O_EDGE_COUNT(O_EDGE_COUNT)
  );

  sobel_matrix3 #(.P_PIXEL_DEPTH(PD), .P_COUNT_BIT_COUNT(2)) u_small (
    .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_PIXEL_MATRIX(I_PIXEL_MATRIX),
    .I_VALID(I_VALID), .O_READY(small_ready), .I_THRESHOLD(I_THRESHOLD),
    .I_CLEAR(I_CLEAR), .O_MAGNITUDE(small_mag), .O_EDGE(small_edge),
    .O_VALID(small_valid), .I_READY(I_READY), .O_EDGE_COUNT(small_count)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: Sobel kernels on plain integers, |Gx|+|Gy| clipped to the pixel range.
  function automatic exp_t model(input logic [8*PD-1:0] m, input logic [PD-1:0] thr);
    int p[8];
    int gx, gy, s;
    exp_t e;
    for (int i = 0; i < 8; i++) p[i] = int'(m[8*PD-1-PD*i -: PD]);
    gx = (p[2] + 2*p[4] + p[7]) - (p[0] + 2*p[3] + p[5]);
    gy = (p[5] + 2*p[6] + p[7]) - (p[0] + 2*p[1] + p[2]);
    s  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (s > 255) s = 255;
    e.mag       = PD'(s);
    e.edge_flag = (s >= int'(thr));
    return e;
  endfunction

  function automatic logic [8*PD-1:0] pack(input int tl, t, tr, ml, mr, bl, b, br);
    return {PD'(tl), PD'(t), PD'(tr), PD'(ml), PD'(mr), PD'(bl), PD'(b), PD'(br)};
  endfunction

  // Monitor: all handshakes that will fire on the next rising edge are
  // decided by the levels seen at the falling edge.
  always @(negedge I_CLK) begin
    exp_t e;
    if (!I_RESET_N) begin
      check("rst_valid", O_VALID, 0);
      check("rst_mag", O_MAGNITUDE, 0);
      check("rst_edge", O_EDGE, 0);
      check("rst_count", O_EDGE_COUNT, 0);
      check("rst_ready", O_READY, 1);
      sb.delete();
      model_count = 0;
      model_small = 0;
    end else begin
      check("edge_count", O_EDGE_COUNT, model_count);
      check("edge_count_sat2", small_count, model_small);
      if (O_VALID) begin
        if (sb.size() == 0) begin
          check("stale_output", O_VALID, 0);
        end else begin
          check("magnitude", O_MAGNITUDE, sb[0].mag);
          check("edge", O_EDGE, sb[0].edge_flag);
        end
      end
      if (I_CLEAR) begin
        sb.delete();
        model_count = 0;
        model_small = 0;
      end else begin
        if (O_VALID && I_READY && sb.size() > 0) begin
          e = sb.pop_front();
          if (e.edge_flag) begin
            if (model_count < (1 << 20) - 1) model_count++;
            if (model_small < 3) model_small++;
          end
        end
        if (I_VALID && O_READY) sb.push_back(model(I_PIXEL_MATRIX, I_THRESHOLD));
      end
    end
  end

  always @(posedge I_CLK) begin
    #1;
    if (rand_ready) I_READY = ($urandom % 4) != 0;
  end

  task automatic send(input logic [8*PD-1:0] m, input logic [PD-1:0] thr);
    int  n = 0;
    bit  acc = 1'b0;
    I_PIXEL_MATRIX = m;
    I_THRESHOLD    = thr;
    I_VALID        = 1'b1;
    do begin
      @(negedge I_CLK);
      acc = O_READY;
      @(posedge I_CLK);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
    I_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge I_CLK);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [8*PD-1:0] m;
    int base;

    idle(3);
    I_RESET_N = 1'b1;
    idle(1);

    // Directed patterns
    send('0, 8'd1);
    idle(2);
    check("zero_count", O_EDGE_COUNT, 0);
    send(pack(0, 0, 255, 0, 255, 0, 0, 255), 8'd200);
    idle(2);
    check("sat_count", O_EDGE_COUNT, 1);
    send(pack(100, 100, 100, 0, 0, 110, 110, 110), 8'd40);
    send(pack(100, 100, 100, 0, 0, 110, 110, 110), 8'd41);
    drain();
    check("thr_count", O_EDGE_COUNT, 2);

    // Backpressure with three back-to-back matrices
    I_READY = 1'b0;
    fork
      begin
        send(pack(10, 20, 30, 40, 50, 60, 70, 80), 8'd5);
        send(pack(200, 0, 0, 200, 0, 200, 0, 0), 8'd100);
        send(pack(1, 2, 3, 4, 5, 6, 7, 8), 8'd255);
      end
      begin
        repeat (3) @(negedge I_CLK);
        check("bp_ready_low", O_READY, 0);
        idle(2);
        I_READY = 1'b1;
      end
    join
    drain();

    // Randomised traffic
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom % 5 == 0) idle(1);
      base = $urandom % 256;
      for (int i = 0; i < 8; i++) begin
        if (k % 2 == 0) m[8*PD-1-PD*i -: PD] = PD'($urandom);
        else            m[8*PD-1-PD*i -: PD] = PD'((base + $urandom % 24) % 256);
      end
      send(m, ($urandom % 4 == 0) ? 8'd0 : PD'($urandom));
    end
    rand_ready = 1'b0;
    I_READY = 1'b1;
    drain();

    // Clear with two results in flight, plus a same-cycle input to discard
    I_READY = 1'b0;
    send(pack(0, 0, 255, 0, 255, 0, 0, 255), 8'd0);
    send(pack(255, 0, 0, 255, 0, 255, 0, 0), 8'd0);
    I_CLEAR = 1'b1;
    I_VALID = 1'b1;
    idle(1);
    I_CLEAR = 1'b0;
    I_VALID = 1'b0;
    @(negedge I_CLK);
    check("clear_valid", O_VALID, 0);
    check("clear_count", O_EDGE_COUNT, 0);
    I_READY = 1'b1;
    idle(4);

    // Asynchronous reset with two results in flight
    I_READY = 1'b0;
    send(pack(9, 9, 9, 0, 0, 99, 99, 99), 8'd0);
    send(pack(0, 0, 255, 0, 255, 0, 0, 255), 8'd0);
    #2 I_RESET_N = 1'b0;
    #1;
    check("areset_valid", O_VALID, 0);
    check("areset_count", O_EDGE_COUNT, 0);
    check("areset_ready", O_READY, 1);
    idle(2);
    I_RESET_N = 1'b1;
    I_READY = 1'b1;
    idle(4);

    // Counter saturation: five edges into the 2-bit counter
    for (int k = 0; k < 5; k++) send(PD'(k * 37) * 64'h0101_0101_0101_0101, 8'd0);
    drain();
    idle(1);
    check("sat2_final", small_count, 3);
    check("count_final", O_EDGE_COUNT, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
